// File: rtl/output_digit_serializer.sv
// Converts an unsigned binary value to BCD by sequential double-dabble and
// streams the decimal digits MSD-first over a valid/ready handshake.
module output_digit_serializer #(
    parameter int WIDTH       = 16,
    parameter int N_DIG       = 5,
    parameter int SUPPRESS_LZ = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_busy,
    output logic             o_dig_valid,
    input  logic             i_dig_ready,
    output logic [3:0]       o_digit,
    output logic             o_dig_last,
    output logic             o_done
);

    localparam int BW = 4 * N_DIG;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_SKIP, S_EMIT} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_bin;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic             r_done;

    logic [BW-1:0]    w_adj;
    logic [3:0]       w_nib;
    logic             w_conv_end, w_skip, w_hs, w_last_hs;

    // Per-nibble +3 correction; nibbles never carry into each other.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < N_DIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < N_DIG; i++) begin
            if (r_idx == IW'(i))
                w_nib = r_bcd[4*i +: 4];
        end
    end

    assign w_conv_end = (r_cnt == CW'(WIDTH - 1));
    assign w_skip     = (SUPPRESS_LZ != 0) && (r_idx != '0) && (w_nib == 4'd0);
    assign w_hs       = (r_state == S_EMIT) && i_dig_ready;
    assign w_last_hs  = w_hs && (r_idx == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start)    w_next = S_CONV;
            S_CONV: if (w_conv_end) w_next = S_SKIP;
            S_SKIP: if (!w_skip)    w_next = S_EMIT;
            S_EMIT: if (w_last_hs)  w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_idx  <= IW'(N_DIG - 1);
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_bin <= i_value;
                    r_bcd <= '0;
                    r_cnt <= '0;
                    r_idx <= IW'(N_DIG - 1);
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + CW'(1);
                end
                S_SKIP: if (w_skip) r_idx <= r_idx - IW'(1);
                S_EMIT: if (w_hs && (r_idx != '0)) r_idx <= r_idx - IW'(1);
                default: ;
            endcase
        end
    end

    // Handshake outputs decode from registered state only, never from i_dig_ready.
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_dig_valid = (r_state == S_EMIT);
        o_digit     = (r_state == S_EMIT) ? w_nib : 4'd0;
        o_dig_last  = (r_state == S_EMIT) && (r_idx == '0);
        o_done      = r_done;
    end

endmodule
